// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// APB3 requester. Turns one valid/ready command into exactly one APB transfer
// and returns exactly one response. A wait-state watchdog aborts a transfer
// whose completer holds pready low for too long, so the bus cannot hang.
//
// Parameters
//   DATA_WIDTH      width of pwdata/prdata and of command/response data
//   ADDR_WIDTH      width of paddr and of the command address
//   TIMEOUT_CYCLES  ACCESS edges with pready=0 before an abort (0 = no watchdog)
//
// Ports
//   pclk, preset_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake; cmd_ready is high only in IDLE
//   cmd_write, cmd_addr,
//   cmd_wdata                command contents, captured on acceptance
//   rsp_valid                one-cycle pulse when a transfer finishes
//   rsp_rdata                read data (0 for writes and timeouts), held
//   rsp_slverr               completer error or timeout, held
//   rsp_timeout              transfer aborted by the watchdog, held
//   psel, penable, pwrite,
//   paddr, pwdata            APB request signals (all registered)
//   prdata, pready, pslverr  APB completer response
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  // APB side
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  // Wait counter is wide enough to hold TIMEOUT_CYCLES; at least one bit so
  // the design still elaborates with the watchdog disabled.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Limit in one extra bit so "count + 1" can be compared without overflow.
  localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);
  localparam logic [CNT_W:0] CNT_ONE     = (CNT_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state_q,       state_d;
  logic                    psel_q,        psel_d;
  logic                    penable_q,     penable_d;
  logic                    pwrite_q,      pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,      pwdata_d;
  logic                    rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                    rsp_slverr_q,  rsp_slverr_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]        wait_cnt_q,    wait_cnt_d;
  logic                    timeout_hit;

  // Saturating increment: the counter parks at all-ones instead of wrapping,
  // which matters only when the watchdog is disabled.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // wait_cnt_q counts the pready=0 edges already seen in this ACCESS phase,
  // so the current edge is the limit-th one when wait_cnt_q + 1 reaches it.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) &&
                  (({1'b0, wait_cnt_q} + CNT_ONE) >= TIMEOUT_LIM);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Everything holds by default; rsp_valid is the only pulse.
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        // Address/data are only reloaded on acceptance, so the bus stays
        // quiet between transfers.
        if (cmd_valid) begin
          pwrite_d   = cmd_write;
          paddr_d    = cmd_addr;
          pwdata_d   = cmd_wdata;
          psel_d     = 1'b1;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          // A ready completer beats a watchdog expiring on the same edge.
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = sat_inc(wait_cnt_q);
          if (timeout_hit) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_slverr_d  = 1'b1;
            rsp_timeout_d = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = IDLE;
          end
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_slverr, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  apb_master #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } rsp_t;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } trc_t;

  rsp_t rsp_q[$];
  trc_t trc_q[$];

  // completer model configuration
  int            slv_wait = 0;
  logic          slv_err = 1'b0;
  logic          slv_err_early = 1'b0;
  int            acc_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge pclk) cyc++;

  // Completer: pready rises after slv_wait ACCESS cycles; pslverr during
  // waits follows slv_err_early so it can be shown to be ignored.
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready  = (acc_cnt >= slv_wait);
      pslverr = pready ? slv_err : slv_err_early;
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      acc_cnt = 0;
    end
  end

  // Response scoreboard.
  always @(negedge pclk) begin
    rsp_t e;
    if (preset_n && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_rdata",   32'(rsp_rdata),   32'(e.rdata));
        check("rsp_slverr",  32'(rsp_slverr),  32'(e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end
  end

  // APB request trace scoreboard, sampled on the first ACCESS cycle.
  logic pen_prev = 1'b0;
  always @(negedge pclk) begin
    trc_t t;
    if (psel && penable && !pen_prev) begin
      if (trc_q.size() == 0) begin
        check("trc_unexpected", 32'(penable), 32'd0);
      end else begin
        t = trc_q.pop_front();
        check("trc_pwrite", 32'(pwrite), 32'(t.w));
        check("trc_paddr",  32'(paddr),  32'(t.a));
        check("trc_pwdata", 32'(pwdata), 32'(t.d));
      end
    end
    pen_prev = penable;
  end

  task automatic run_cmd(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int wait_n, input logic err,
                         input logic err_early, input logic [DW-1:0] rd,
                         input logic [DW-1:0] exp_rd, input logic exp_err,
                         input logic exp_to, input int exp_acc);
    int n;
    int guard;
    @(negedge pclk);
    slv_wait      = wait_n;
    slv_err       = err;
    slv_err_early = err_early;
    prdata        = rd;
    cmd_write     = w;
    cmd_addr      = a;
    cmd_wdata     = d;
    cmd_valid     = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge pclk);
      guard++;
    end
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    rsp_q.push_back('{exp_rd, exp_err, exp_to});
    trc_q.push_back('{w, a, d});
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    check({tag, "_setup"}, {29'd0, psel, penable, cmd_ready}, {29'd0, 3'b100});
    @(posedge pclk); #1;
    check({tag, "_access"}, {30'd0, psel, penable}, {30'd0, 2'b11});
    n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
    end while (!rsp_valid && n < 40);
    check({tag, "_acc_cycles"}, 32'(n), 32'(exp_acc));
    check({tag, "_idle"}, {30'd0, psel, penable}, 32'd0);
    check({tag, "_paddr_hold"}, 32'(paddr), 32'(a));
    @(posedge pclk); #1;
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdata_hold"}, 32'(rsp_rdata), 32'(exp_rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int guard;
    int acc[3];
    logic [AW-1:0] ba[3];
    logic [DW-1:0] bd[3];
    ba[0] = 3'd1; bd[0] = 8'h10;
    ba[1] = 3'd0; bd[1] = 8'h83;
    ba[2] = 3'd0; bd[2] = 8'h13;

    preset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    #2;
    check("reset_bus", {29'd0, psel, penable, pwrite}, 32'd0);
    check("reset_rsp", {29'd0, rsp_valid, rsp_slverr, rsp_timeout}, 32'd0);
    check("reset_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;

    // write, zero wait
    run_cmd("wr0", 1'b1, 3'b010, 8'h5A, 0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1);
    // read, 3 wait states; also pready on the 4th (timeout) edge wins
    run_cmd("rd3", 1'b0, 3'b011, 8'h00, 3, 1'b0, 1'b0, 8'h93, 8'h93, 1'b0, 1'b0, 4);
    // completer error
    run_cmd("serr", 1'b0, 3'b111, 8'h00, 0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1);
    // pslverr while pready=0 is ignored
    run_cmd("early", 1'b0, 3'b001, 8'h00, 2, 1'b0, 1'b1, 8'h5C, 8'h5C, 1'b0, 1'b0, 3);
    // pready stuck low: watchdog abort
    run_cmd("tmo", 1'b0, 3'b100, 8'h00, 100, 1'b0, 1'b0, 8'hEE, 8'h00, 1'b1, 1'b1, 4);
    check("tmo_flags_hold", {30'd0, rsp_slverr, rsp_timeout}, 32'd3);

    // reset in the middle of ACCESS
    @(negedge pclk);
    slv_wait  = 100;
    prdata    = 8'h77;
    cmd_write = 1'b1;
    cmd_addr  = 3'd5;
    cmd_wdata = 8'hC3;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge pclk);
      guard++;
    end
    trc_q.push_back('{1'b1, 3'd5, 8'hC3});
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    check("rst_mid_pen", 32'(penable), 32'd1);
    @(posedge pclk); #2;
    preset_n = 1'b0;
    #1;
    check("rst_async_bus", {29'd0, psel, penable, pwrite}, 32'd0);
    check("rst_async_addr", {21'd0, paddr, pwdata}, 32'd0);
    check("rst_async_rsp", {29'd0, rsp_valid, rsp_slverr, rsp_timeout}, 32'd0);
    check("rst_async_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    slv_wait = 0;
    @(posedge pclk); #1;
    check("rst_release_ready", 32'(cmd_ready), 32'd1);
    run_cmd("post_rst", 1'b0, 3'd6, 8'h00, 1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 2);

    // back-to-back with cmd_valid held
    @(negedge pclk);
    slv_wait      = 0;
    slv_err       = 1'b0;
    slv_err_early = 1'b0;
    prdata        = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cmd_write = 1'b1;
      cmd_addr  = ba[i];
      cmd_wdata = bd[i];
      cmd_valid = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 20) begin
        @(negedge pclk);
        guard++;
      end
      acc[i] = cyc;
      rsp_q.push_back('{8'h00, 1'b0, 1'b0});
      trc_q.push_back('{1'b1, ba[i], bd[i]});
      @(negedge pclk);
    end
    cmd_valid = 1'b0;
    check("b2b_gap01", 32'(acc[1] - acc[0]), 32'd3);
    check("b2b_gap12", 32'(acc[2] - acc[1]), 32'd3);
    guard = 0;
    while (rsp_q.size() != 0 && guard < 30) begin
      @(negedge pclk);
      guard++;
    end
    repeat (4) @(negedge pclk);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    check("trc_q_empty", 32'(trc_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
